test_status_monitor: RTL and testbench
======================================

// Module: test_status_monitor
// PURPOSE
//   Synthesizable pass/fail/timeout monitor for self-checking programs.
//   Generalises the store-snooping end-of-test check and the cycle monitor into one block.
//   Snoops the memory-stage store bus, counts cycles, retired instructions and writeback
//   stalls, and latches a sticky verdict. Sits beside riscv_top; usable in bench and FPGA.
// PARAMETERS
//   DATA_WIDTH     32       width of store address/data buses
//   CNT_WIDTH      32       width of each performance counter
//   TOHOST_ADDR    100      mailbox address; store of PASS_VALUE here = pass
//   PASS_VALUE     25       data value signalling pass
//   WIN_LO         90       exclusive lower bound of the watched address window
//   WIN_HI         120      exclusive upper bound of the watched address window
//   IGNORE_ADDR    96       address inside the window that never causes a verdict
//   TIMEOUT_CYCLES 1000000  cycle count at which RUN -> TIMEOUT; 0 disables
// PORTS
//   clk_i          in   1           clock
//   reset_i        in   1           reset, asynchronous, active-low
//   store_valid_i  in   1           store in memory stage (mem_write_m)
//   store_addr_i   in   DATA_WIDTH  store address (alu_result_m)
//   store_data_i   in   DATA_WIDTH  store data (write_data_m)
//   valid_w_i      in   1           writeback-stage instruction valid
//   stall_w_i      in   1           writeback stage stalled
//   state_o        out  2           0 IDLE, 1 RUN, 2 PASS, 3 FAIL; TIMEOUT encodes as 3 with timeout_o=1
//   done_o         out  1           verdict latched (state PASS/FAIL/TIMEOUT)
//   pass_o         out  1           verdict is PASS
//   timeout_o      out  1           verdict is TIMEOUT
//   fail_code_o    out  DATA_WIDTH  data of the failing store; 0 otherwise
//   cycle_cnt_o    out  CNT_WIDTH   cycles spent in RUN
//   instret_cnt_o  out  CNT_WIDTH   retired instructions (valid_w_i & ~stall_w_i)
//   stall_cnt_o    out  CNT_WIDTH   cycles with stall_w_i=1
// BEHAVIOUR
//   - Reset (reset_i=0, async): state IDLE; all counters, done_o, pass_o, timeout_o and fail_code_o = 0.
//   - IDLE -> RUN on the first rising edge with reset_i=1. No counting or snooping in IDLE.
//   - RUN, per rising edge: cycle_cnt++. instret_cnt++ if valid_w_i & ~stall_w_i.
//     stall_cnt++ if stall_w_i. Counters saturate at all-ones and never wrap.
//   - Snoop, RUN only; "hit" = store_valid_i & WIN_LO<addr<WIN_HI & addr!=IGNORE_ADDR.
//     hit & addr==TOHOST_ADDR & data==PASS_VALUE -> PASS.
//     hit & any other data!=0 (incl. TOHOST_ADDR with wrong value) -> FAIL, fail_code_o=data.
//     hit & data==0 -> no action.
//   - Timeout: in RUN, if TIMEOUT_CYCLES!=0 and cycle_cnt (pre-increment) == TIMEOUT_CYCLES-1 -> TIMEOUT.
//   - Priority on the same edge: PASS > FAIL > TIMEOUT.
//   - Terminal states are sticky until reset. All counters and fail_code_o freeze.
//     Further stores are ignored.
//   - Latency: the verdict is visible the cycle after the qualifying edge.
//     The counters include that final RUN cycle.
//   - All outputs are registered. Reset asserted mid-run clears everything immediately
//     (async). After release, the block restarts at IDLE.
// TESTING
//   1. Reset release, then store addr=100 data=25 at RUN cycle 10 -> cycle after: done_o=1,
//      pass_o=1, state_o=2, cycle_cnt_o=10, then frozen.
//   2. Store addr=104 data=7 -> state_o=3, pass_o=0, timeout_o=0, fail_code_o=7.
//      A later addr=100/25 store leaves it FAIL.
//   3. Stores to addr=96 data=5, addr=100 data=0, addr=200 data=9 -> stays RUN, done_o=0.
//   4. TIMEOUT_CYCLES=50, no stores -> after 50 RUN cycles: timeout_o=1, state_o=3,
//      cycle_cnt_o=50. Pass store on that same edge -> PASS wins.
//   5. 20 RUN cycles with valid_w_i=1 and stall_w_i=1 on 6 of them -> instret_cnt_o=14,
//      stall_cnt_o=6. With CNT_WIDTH=4, cycle_cnt_o saturates at 15.
//   6. Assert reset_i=0 mid-RUN between clock edges -> outputs clear with no clock edge.
//      Release -> IDLE, then RUN.

Source files
------------

// File: rtl/test_status_monitor.sv
// End-of-test monitor: snoops stores for a tohost verdict, counts RUN cycles,
// retired instructions and writeback stalls, and latches a sticky verdict.
module test_status_monitor #(
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int TOHOST_ADDR    = 100,
  parameter int PASS_VALUE     = 25,
  parameter int WIN_LO         = 90,
  parameter int WIN_HI         = 120,
  parameter int IGNORE_ADDR    = 96,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  store_valid_i,
  input  logic [DATA_WIDTH-1:0] store_addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic                  valid_w_i,
  input  logic                  stall_w_i,
  output logic [1:0]            state_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] fail_code_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  instret_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam logic [DATA_WIDTH-1:0] TOHOST_A = DATA_WIDTH'(TOHOST_ADDR);
  localparam logic [DATA_WIDTH-1:0] PASS_V   = DATA_WIDTH'(PASS_VALUE);
  localparam logic [DATA_WIDTH-1:0] LO_A     = DATA_WIDTH'(WIN_LO);
  localparam logic [DATA_WIDTH-1:0] HI_A     = DATA_WIDTH'(WIN_HI);
  localparam logic [DATA_WIDTH-1:0] IGN_A    = DATA_WIDTH'(IGNORE_ADDR);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  // Compared at 64 bits so a limit beyond the counter range can never alias.
  localparam logic [63:0]           TO_LAST  = 64'(TIMEOUT_CYCLES) - 64'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t                state_reg;
  logic [1:0]            state_code_reg;
  logic                  done_reg;
  logic                  pass_reg;
  logic                  timeout_reg;
  logic [DATA_WIDTH-1:0] fail_code_reg;
  logic [CNT_WIDTH-1:0]  cycle_cnt_reg;
  logic [CNT_WIDTH-1:0]  instret_cnt_reg;
  logic [CNT_WIDTH-1:0]  stall_cnt_reg;

  logic hit;
  logic is_pass;
  logic is_fail;
  logic is_timeout;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    hit        = store_valid_i && (store_addr_i > LO_A) && (store_addr_i < HI_A) &&
                 (store_addr_i != IGN_A);
    is_pass    = hit && (store_addr_i == TOHOST_A) && (store_data_i == PASS_V);
    is_fail    = hit && !is_pass && (store_data_i != '0);
    is_timeout = (TIMEOUT_CYCLES != 0) && (64'(cycle_cnt_reg) == TO_LAST);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg       <= ST_IDLE;
      state_code_reg  <= 2'd0;
      done_reg        <= 1'b0;
      pass_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      fail_code_reg   <= '0;
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
      stall_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg      <= ST_RUN;
          state_code_reg <= 2'd1;
        end
        ST_RUN: begin
          // Counters advance on the verdict edge too, then freeze.
          cycle_cnt_reg <= sat_inc(cycle_cnt_reg);
          if (valid_w_i && !stall_w_i) instret_cnt_reg <= sat_inc(instret_cnt_reg);
          if (stall_w_i) stall_cnt_reg <= sat_inc(stall_cnt_reg);
          if (is_pass) begin
            state_reg      <= ST_PASS;
            state_code_reg <= 2'd2;
            done_reg       <= 1'b1;
            pass_reg       <= 1'b1;
          end else if (is_fail) begin
            state_reg      <= ST_FAIL;
            state_code_reg <= 2'd3;
            done_reg       <= 1'b1;
            fail_code_reg  <= store_data_i;
          end else if (is_timeout) begin
            state_reg      <= ST_TIMEOUT;
            state_code_reg <= 2'd3;
            done_reg       <= 1'b1;
            timeout_reg    <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state_o       = state_code_reg;
  assign done_o        = done_reg;
  assign pass_o        = pass_reg;
  assign timeout_o     = timeout_reg;
  assign fail_code_o   = fail_code_reg;
  assign cycle_cnt_o   = cycle_cnt_reg;
  assign instret_cnt_o = instret_cnt_reg;
  assign stall_cnt_o   = stall_cnt_reg;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor: a 32-bit counter instance with a
// 50-cycle timeout and a 4-bit counter instance sharing the same stimulus.
module tb_test_status_monitor;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        store_valid = 1'b0;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;
  logic        valid_w = 1'b0;
  logic        stall_w = 1'b0;

  logic [1:0]  state;
  logic        done, pass, timeout;
  logic [31:0] fail_code, cycle_cnt, instret_cnt, stall_cnt;

  logic [1:0]  s_state;
  logic        s_done, s_pass, s_timeout;
  logic [31:0] s_fail_code;
  logic [3:0]  s_cycle_cnt, s_instret_cnt, s_stall_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  test_status_monitor #(.TIMEOUT_CYCLES(50)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .store_valid_i(store_valid), .store_addr_i(store_addr), .store_data_i(store_data),
    .valid_w_i(valid_w), .stall_w_i(stall_w),
    .state_o(state), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .fail_code_o(fail_code), .cycle_cnt_o(cycle_cnt),
    .instret_cnt_o(instret_cnt), .stall_cnt_o(stall_cnt)
  );

  test_status_monitor #(.CNT_WIDTH(4)) dut_small (
    .clk_i(clk), .reset_i(reset_i),
    .store_valid_i(store_valid), .store_addr_i(store_addr), .store_data_i(store_data),
    .valid_w_i(valid_w), .stall_w_i(stall_w),
    .state_o(s_state), .done_o(s_done), .pass_o(s_pass), .timeout_o(s_timeout),
    .fail_code_o(s_fail_code), .cycle_cnt_o(s_cycle_cnt),
    .instret_cnt_o(s_instret_cnt), .stall_cnt_o(s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_store();
    store_valid = 1'b0;
    store_addr  = '0;
    store_data  = '0;
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d);
    store_valid = 1'b1;
    store_addr  = a;
    store_data  = d;
  endtask

  // Reset, release between edges, then take the IDLE->RUN edge.
  task automatic restart();
    @(negedge clk);
    reset_i = 1'b0;
    clear_store();
    valid_w = 1'b0;
    stall_w = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();
  endtask

  initial begin
    // Test 1: reset state, then pass store on the 10th RUN edge
    #3;
    check_eq("rst_state", state, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cycle", cycle_cnt, 0);
    check_eq("rst_fail_code", fail_code, 0);
    restart();
    check_eq("t1_run_state", state, 1);
    check_eq("t1_run_cycle", cycle_cnt, 0);
    repeat (9) tick();
    check_eq("t1_pre_done", done, 0);
    put_store(32'd100, 32'd25);
    tick();
    clear_store();
    check_eq("t1_state", state, 2);
    check_eq("t1_done", done, 1);
    check_eq("t1_pass", pass, 1);
    check_eq("t1_cycle", cycle_cnt, 10);
    repeat (3) tick();
    check_eq("t1_frozen_cycle", cycle_cnt, 10);
    check_eq("t1_frozen_state", state, 2);

    // Test 2: fail store, later pass store ignored
    restart();
    repeat (2) tick();
    put_store(32'd104, 32'd7);
    tick();
    clear_store();
    check_eq("t2_state", state, 3);
    check_eq("t2_pass", pass, 0);
    check_eq("t2_timeout", timeout, 0);
    check_eq("t2_fail_code", fail_code, 7);
    check_eq("t2_cycle", cycle_cnt, 3);
    put_store(32'd100, 32'd25);
    tick();
    clear_store();
    check_eq("t2_sticky_state", state, 3);
    check_eq("t2_sticky_code", fail_code, 7);

    // Test 3: stores that must not cause a verdict
    restart();
    put_store(32'd96, 32'd5);  tick();
    put_store(32'd100, 32'd0); tick();
    put_store(32'd200, 32'd9); tick();
    put_store(32'd90, 32'd9);  tick();
    put_store(32'd120, 32'd9); tick();
    clear_store();
    check_eq("t3_state", state, 1);
    check_eq("t3_done", done, 0);
    check_eq("t3_fail_code", fail_code, 0);
    check_eq("t3_cycle", cycle_cnt, 5);
    // Wrong value at the mailbox itself is a failure
    put_store(32'd100, 32'd24);
    tick();
    clear_store();
    check_eq("t3_tohost_bad_state", state, 3);
    check_eq("t3_tohost_bad_code", fail_code, 24);

    // Test 4a: timeout after 50 RUN cycles
    restart();
    repeat (49) tick();
    check_eq("t4_pre_state", state, 1);
    tick();
    check_eq("t4_timeout", timeout, 1);
    check_eq("t4_state", state, 3);
    check_eq("t4_done", done, 1);
    check_eq("t4_pass", pass, 0);
    check_eq("t4_cycle", cycle_cnt, 50);
    tick();
    check_eq("t4_frozen_cycle", cycle_cnt, 50);

    // Test 4b: pass on the timeout edge wins
    restart();
    repeat (49) tick();
    put_store(32'd100, 32'd25);
    tick();
    clear_store();
    check_eq("t4b_state", state, 2);
    check_eq("t4b_pass", pass, 1);
    check_eq("t4b_timeout", timeout, 0);
    check_eq("t4b_cycle", cycle_cnt, 50);

    // Test 4c: fail on the timeout edge wins over timeout
    restart();
    repeat (49) tick();
    put_store(32'd104, 32'd3);
    tick();
    clear_store();
    check_eq("t4c_state", state, 3);
    check_eq("t4c_timeout", timeout, 0);
    check_eq("t4c_fail_code", fail_code, 3);

    // Test 5: instret/stall counting and 4-bit saturation
    restart();
    for (int i = 0; i < 20; i++) begin
      valid_w = 1'b1;
      stall_w = (i % 3 == 1) && (i < 18);
      tick();
    end
    valid_w = 1'b0;
    stall_w = 1'b0;
    check_eq("t5_instret", instret_cnt, 14);
    check_eq("t5_stall", stall_cnt, 6);
    check_eq("t5_cycle", cycle_cnt, 20);
    check_eq("t5_small_cycle_sat", s_cycle_cnt, 15);
    check_eq("t5_small_instret", s_instret_cnt, 14);
    check_eq("t5_small_stall", s_stall_cnt, 6);
    repeat (3) tick();
    check_eq("t5_small_cycle_hold", s_cycle_cnt, 15);

    // Test 6: asynchronous reset mid-run
    restart();
    repeat (5) tick();
    check_eq("t6_pre_cycle", cycle_cnt, 5);
    #2;
    reset_i = 1'b0;
    #1;
    check_eq("t6_async_state", state, 0);
    check_eq("t6_async_cycle", cycle_cnt, 0);
    check_eq("t6_async_small_cycle", s_cycle_cnt, 0);
    #1;
    reset_i = 1'b1;
    #1;
    check_eq("t6_idle_state", state, 0);
    tick();
    check_eq("t6_run_state", state, 1);
    check_eq("t6_run_cycle", cycle_cnt, 0);
    tick();
    check_eq("t6_count_cycle", cycle_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
